// File: rtl/apb_fifo_bridge_pkg.sv
// apb_fifo_bridge shared types: FSM states, register map and STATUS bits.
// Imported by the bridge RTL and its bench.
package apb_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_POP,
    RD_CAP,
    RESP
  } state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_EMPTY = 1;
  localparam int ST_ERR      = 2;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_fifo_bridge_if.sv
// APB bus bundle for apb_fifo_bridge.
// master drives the request, slave returns data/ready/error.
interface apb_fifo_bridge_if #(
  parameter int PADDR_WIDTH = 32,
  parameter int PDATA_WIDTH = 32
);
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [PADDR_WIDTH-1:0] paddr;
  logic [PDATA_WIDTH-1:0] pwdata;
  logic [PDATA_WIDTH-1:0] prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_fifo_bridge.sv
// APB slave turning DATA/STATUS register accesses into per-channel FIFO strobes.
// Optional APB_FIFO_BRIDGE_WAIT_EN: stall full/empty DATA accesses up to TIMEOUT cycles.
module apb_fifo_bridge
  import apb_fifo_pkg::*;
#(
  parameter int PDATA_WIDTH = 32,
  parameter int PADDR_WIDTH = 32,
  parameter int FDATA_WIDTH = 32,
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  apb_fifo_bridge_if.slave              apb,
  input  logic [NUM_CH-1:0]             tx_full,
  output logic [NUM_CH*FDATA_WIDTH-1:0] tx_wdata,
  output logic [NUM_CH-1:0]             tx_wrn,
  input  logic [NUM_CH-1:0]             rx_empty,
  input  logic [NUM_CH*FDATA_WIDTH-1:0] rx_rdata,
  output logic [NUM_CH-1:0]             rx_rdn
);

  localparam int CW = ch_bits(NUM_CH);
  localparam int FW = FDATA_WIDTH;
  localparam int PW = PDATA_WIDTH;

  typedef logic [NUM_CH-1:0][FW-1:0] lanes_t;

  state_t                 state, state_n;
  logic [PADDR_WIDTH-1:0] addr;
  logic [3:0]             a_chf;
  logic [CW-1:0]          a_ch, ch, ch_n;
  logic [1:0]             a_reg;
  logic                   a_vld, req;
  logic [PW-1:0]          prdata_q, prdata_n;
  logic                   pready_q, pready_n;
  logic                   pslverr_q, pslverr_n;
  logic [NUM_CH-1:0]      tx_wrn_n, rx_rdn_n;
  logic [NUM_CH-1:0]      sticky, sticky_n;
  lanes_t                 txd_q, rxd;
  logic [FW-1:0]          txd_n;
  logic                   tx_ld;
  logic                   err, err_wr, err_vld;
  logic                   unused;

`ifdef APB_FIFO_BRIDGE_WAIT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt, cnt_n;
  logic          wr_q, wr_n;
  logic [FW-1:0] wd_q, wd_n;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  assign addr   = apb.paddr;
  assign a_chf  = addr[7:4];
  assign a_ch   = addr[4+CW-1:4];
  assign a_reg  = addr[3:2];
  // Range check spans the whole 16-slot map so unpopulated slots fault.
  assign a_vld  = {28'd0, a_chf} < 32'(NUM_CH);
  assign req    = apb.psel && apb.penable && !pready_q;
  assign rxd    = rx_rdata;
  assign unused = ^{addr, apb.pwdata};

  always_comb begin
    state_n   = state;
    ch_n      = ch;
    prdata_n  = prdata_q;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    tx_wrn_n  = '0;
    rx_rdn_n  = '0;
    sticky_n  = sticky;
    txd_n     = apb.pwdata[FW-1:0];
    tx_ld     = 1'b0;
    err       = 1'b0;
    err_wr    = apb.pwrite;
    err_vld   = a_vld;
`ifdef APB_FIFO_BRIDGE_WAIT_EN
    cnt_n = cnt;
    wr_n  = wr_q;
    wd_n  = wd_q;
`endif
    unique case (state)
      IDLE: begin
        if (req) begin
          ch_n = a_ch;
`ifdef APB_FIFO_BRIDGE_WAIT_EN
          wr_n  = apb.pwrite;
          wd_n  = apb.pwdata[FW-1:0];
          cnt_n = '0;
`endif
          if (!a_vld || a_reg[1]) begin
            err = 1'b1;
          end else if (a_reg == REG_STATUS) begin
            pready_n = 1'b1;
            state_n  = RESP;
            if (!apb.pwrite) begin
              prdata_n              = '0;
              prdata_n[ST_TX_FULL]  = tx_full[a_ch];
              prdata_n[ST_RX_EMPTY] = rx_empty[a_ch];
              prdata_n[ST_ERR]      = sticky[a_ch];
            end else if (apb.pwdata[ST_ERR]) begin
              sticky_n[a_ch] = 1'b0;
            end
          end else if (apb.pwrite && !tx_full[a_ch]) begin
            tx_wrn_n[a_ch] = 1'b1;
            tx_ld          = 1'b1;
            pready_n       = 1'b1;
            state_n        = RESP;
          end else if (!apb.pwrite && !rx_empty[a_ch]) begin
            rx_rdn_n[a_ch] = 1'b1;
            state_n        = RD_POP;
          end else begin
`ifdef APB_FIFO_BRIDGE_WAIT_EN
            state_n = WR_WAIT;
`else
            err = 1'b1;
`endif
          end
        end
      end
      WR_WAIT: begin
`ifdef APB_FIFO_BRIDGE_WAIT_EN
        err_wr  = wr_q;
        err_vld = 1'b1;
        txd_n   = wd_q;
        if (wr_q && !tx_full[ch]) begin
          tx_wrn_n[ch] = 1'b1;
          tx_ld        = 1'b1;
          pready_n     = 1'b1;
          state_n      = RESP;
        end else if (!wr_q && !rx_empty[ch]) begin
          rx_rdn_n[ch] = 1'b1;
          state_n      = RD_POP;
        end else if (cnt == TW'(TIMEOUT - 1)) begin
          err = 1'b1;
        end else begin
          cnt_n = cnt + TW'(1);
        end
`else
        state_n = IDLE;
`endif
      end
      RD_POP: state_n = RD_CAP;
      RD_CAP: begin
        prdata_n = PW'(rxd[ch]);
        pready_n = 1'b1;
        state_n  = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (err) begin
      pready_n  = 1'b1;
      pslverr_n = 1'b1;
      state_n   = RESP;
      if (!err_wr) prdata_n = '0;
      if (err_vld) sticky_n[ch_n] = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= IDLE;
      ch        <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tx_wrn    <= '0;
      rx_rdn    <= '0;
      txd_q     <= '0;
      sticky    <= '0;
`ifdef APB_FIFO_BRIDGE_WAIT_EN
      cnt       <= '0;
      wr_q      <= 1'b0;
      wd_q      <= '0;
`endif
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      prdata_q  <= prdata_n;
      pready_q  <= pready_n;
      pslverr_q <= pslverr_n;
      tx_wrn    <= tx_wrn_n;
      rx_rdn    <= rx_rdn_n;
      sticky    <= sticky_n;
      if (tx_ld) txd_q[ch_n] <= txd_n;
`ifdef APB_FIFO_BRIDGE_WAIT_EN
      cnt       <= cnt_n;
      wr_q      <= wr_n;
      wd_q      <= wd_n;
`endif
    end
  end

  assign tx_wdata    = txd_q;
  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Scoreboard bench for apb_fifo_bridge: directed cases, random traffic, reset abort.
// Wait-state cases compile in when APB_FIFO_BRIDGE_WAIT_EN is defined.
module tb_apb_fifo_bridge;
  import apb_fifo_pkg::*;

  localparam int NCH = 4;
  localparam int FW  = 32;
  localparam int PW  = 32;
  localparam int AW  = 32;
  localparam int TO  = 4;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  apb_fifo_bridge_if #(.PADDR_WIDTH(AW), .PDATA_WIDTH(PW)) apb ();

  logic [NCH-1:0]    tx_full, tx_wrn, rx_empty, rx_rdn;
  logic [NCH*FW-1:0] tx_wdata, rx_rdata;

  apb_fifo_bridge #(
    .PDATA_WIDTH(PW),
    .PADDR_WIDTH(AW),
    .FDATA_WIDTH(FW),
    .NUM_CH(NCH),
    .TIMEOUT(TO)
  ) dut (
    .pclk(pclk),
    .preset_n(preset_n),
    .apb(apb),
    .tx_full(tx_full),
    .tx_wdata(tx_wdata),
    .tx_wrn(tx_wrn),
    .rx_empty(rx_empty),
    .rx_rdata(rx_rdata),
    .rx_rdn(rx_rdn)
  );

  typedef struct {
    logic          err;
    logic [PW-1:0] data;
    int            lat;
  } rsp_t;

  typedef struct {
    logic          tx;
    int            ch;
    logic [FW-1:0] data;
    int            lat;
  } stb_t;

  rsp_t rsq[$];
  stb_t stq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = 0;
  bit sticky_m[16];
  logic [PW-1:0] last_rd = '0;

`ifdef APB_FIFO_BRIDGE_WAIT_EN
  localparam bit WAIT_MODE = 1'b1;
`else
  localparam bit WAIT_MODE = 1'b0;
`endif

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  rsp_t mr;
  stb_t ms;
  always @(negedge pclk) begin
    if (preset_n && apb.pready) begin
      chk("rsp_queued", 64'(rsq.size() != 0), 1);
      if (rsq.size() != 0) begin
        mr = rsq.pop_front();
        chk("pslverr", 64'(apb.pslverr), 64'(mr.err));
        chk("prdata", 64'(apb.prdata), 64'(mr.data));
        chk("rsp_lat", 64'(cyc - t_start), 64'(mr.lat));
      end
    end
    if (preset_n && (tx_wrn | rx_rdn) != 0) begin
      chk("strobe_onehot", 64'($countones(tx_wrn | rx_rdn)), 1);
      chk("stb_queued", 64'(stq.size() != 0), 1);
      if (stq.size() != 0) begin
        ms = stq.pop_front();
        chk("tx_wrn", 64'(tx_wrn), ms.tx ? 64'(1) << ms.ch : 64'(0));
        chk("rx_rdn", 64'(rx_rdn), ms.tx ? 64'(0) : 64'(1) << ms.ch);
        chk("stb_lat", 64'(cyc - t_start), 64'(ms.lat));
        if (ms.tx) chk("tx_wdata", 64'(tx_wdata[ms.ch*FW +: FW]), 64'(ms.data));
      end
    end
  end

  task automatic xfer(input logic wr, input int chn, input int rg,
                      input logic [PW-1:0] wd, input int drop_at);
    bit done;
    done = 1'b0;
    @(posedge pclk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = AW'(chn * 16 + rg * 4);
    apb.pwdata  = wd;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    t_start     = cyc;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge pclk);
      if (apb.pready) begin
        done = 1'b1;
      end else begin
        @(posedge pclk); #1;
        if (drop_at > 0 && cyc - t_start == drop_at) rx_empty[chn] = 1'b0;
      end
    end
    chk("pready_seen", 64'(done), 1);
    @(posedge pclk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  // Reference: expected outcome from the register map rules.
  task automatic run(input logic wr, input int chn, input int rg,
                     input logic [PW-1:0] wd);
    rsp_t r;
    stb_t s;
    bit ok, blocked;
    ok     = chn < NCH;
    r.err  = 1'b0;
    r.lat  = 1;
    r.data = last_rd;
    if (!ok || rg > 1) begin
      r.err = 1'b1;
    end else if (rg == int'(REG_STATUS)) begin
      if (wr) begin
        if (wd[2]) sticky_m[chn] = 1'b0;
      end else begin
        r.data = PW'({sticky_m[chn], rx_empty[chn], tx_full[chn]});
      end
    end else begin
      blocked = wr ? tx_full[chn] : rx_empty[chn];
      if (blocked) begin
        r.err = 1'b1;
        if (WAIT_MODE) r.lat = TO + 1;
      end else begin
        s.tx   = wr;
        s.ch   = chn;
        s.data = wd[FW-1:0];
        s.lat  = 1;
        stq.push_back(s);
        if (!wr) begin
          r.data = PW'(rx_rdata[chn*FW +: FW]);
          r.lat  = 3;
        end
      end
    end
    if (r.err) begin
      if (!wr) r.data = '0;
      if (ok) sticky_m[chn] = 1'b1;
    end
    last_rd = r.data;
    rsq.push_back(r);
    xfer(wr, chn, rg, wd, 0);
  endtask

  initial begin
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    tx_full     = '0;
    rx_empty    = '1;
    rx_rdata    = '0;
    foreach (sticky_m[i]) sticky_m[i] = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_prdata", 64'(apb.prdata), 0);
    chk("rst_pready", 64'(apb.pready), 0);
    chk("rst_pslverr", 64'(apb.pslverr), 0);
    chk("rst_strobes", 64'({tx_wrn, rx_rdn}), 0);
    chk("rst_tx_wdata", 64'(|tx_wdata), 0);
    preset_n = 1'b1;

    run(1'b1, 2, 0, 32'hA5A5_0001);
    rx_empty[1] = 1'b0;
    rx_rdata[1*FW +: FW] = 32'h1234_5678;
    run(1'b0, 1, 0, '0);

    tx_full[0]  = 1'b1;
    rx_empty[0] = 1'b0;
    run(1'b1, 0, 0, 32'h11);
    run(1'b0, 0, 1, '0);
    run(1'b1, 0, 1, 32'h4);
    run(1'b0, 0, 1, '0);
    tx_full[0] = 1'b0;

    run(1'b0, 5, 0, '0);
    run(1'b1, 5, 0, 32'hDEAD_BEEF);
    run(1'b0, 2, 2, '0);
    run(1'b0, 2, 1, '0);

`ifdef APB_FIFO_BRIDGE_WAIT_EN
    rx_empty[3] = 1'b1;
    rx_rdata[3*FW +: FW] = 32'hCAFE_0003;
    stq.push_back('{1'b0, 3, '0, 4});
    rsq.push_back('{1'b0, 32'hCAFE_0003, 6});
    last_rd = 32'hCAFE_0003;
    xfer(1'b0, 3, 0, '0, 3);
    rx_empty[3] = 1'b1;
    run(1'b0, 3, 0, '0);
`endif

    repeat (60) begin
      tx_full  = NCH'($urandom);
      rx_empty = NCH'($urandom);
      for (int c = 0; c < NCH; c++) rx_rdata[c*FW +: FW] = FW'($urandom);
      run(1'($urandom_range(0, 1)), $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom);
    end

    // Abort a read while the pop strobe is out.
    tx_full  = '0;
    rx_empty = '0;
    @(posedge pclk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = AW'(32'h10);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    @(posedge pclk); #1;
    chk("rdpop_strobe", 64'(rx_rdn), 64'(4'b0010));
    preset_n = 1'b0;
    #1;
    chk("abort_prdata", 64'(apb.prdata), 0);
    chk("abort_pready", 64'(apb.pready), 0);
    chk("abort_pslverr", 64'(apb.pslverr), 0);
    chk("abort_strobes", 64'({tx_wrn, rx_rdn}), 0);
    chk("abort_tx_wdata", 64'(|tx_wdata), 0);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    foreach (sticky_m[i]) sticky_m[i] = 1'b0;
    last_rd = '0;
    repeat (2) @(posedge pclk);
    #1;
    preset_n = 1'b1;
    rx_rdata[1*FW +: FW] = 32'h600D_0001;
    run(1'b0, 0, 1, '0);
    run(1'b0, 1, 0, '0);

    repeat (4) @(posedge pclk);
    chk("rsq_drained", 64'(rsq.size()), 0);
    chk("stq_drained", 64'(stq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
